sync_bank: RTL



---
 rtl/sync_bank.sv | 82 ++++++++
 1 files changed

// File: rtl/sync_bank.sv
// Multi-channel single-bit synchroniser bank into the clk_b domain with edge pulses.
// Define SYNC_BANK_FILTER_EN to add a per-channel stability filter (FILT_CYC cycles).
module sync_bank #(
  parameter int              N_CH     = 4,
  parameter int              STAGES   = 2,
  parameter logic [N_CH-1:0] RST_VAL  = '0,
  parameter int              FILT_CYC = 3
) (
  input  logic            clk_b,
  input  logic            rst_b_n,
  input  logic [N_CH-1:0] in_a,
  output logic [N_CH-1:0] out_b,
  output logic [N_CH-1:0] rise_b,
  output logic [N_CH-1:0] fall_b
);

  if (N_CH < 1 || STAGES < 2 || FILT_CYC < 1) begin : g_bad_param
    $error("sync_bank: illegal parameters N_CH=%0d STAGES=%0d FILT_CYC=%0d",
           N_CH, STAGES, FILT_CYC);
  end

  logic [N_CH-1:0] sync_q [STAGES];
  logic [N_CH-1:0] sync_lvl;
  logic [N_CH-1:0] prev_q;

  always_ff @(posedge clk_b or negedge rst_b_n) begin
    if (!rst_b_n) begin
      for (int k = 0; k < STAGES; k++) sync_q[k] <= RST_VAL;
    end else begin
      sync_q[0] <= in_a;
      for (int k = 1; k < STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_lvl = sync_q[STAGES-1];

`ifdef SYNC_BANK_FILTER_EN
  localparam int CW = $clog2(FILT_CYC + 1);

  logic [CW-1:0]   cnt_q [N_CH];
  logic [CW-1:0]   cnt_d [N_CH];
  logic [N_CH-1:0] out_q;
  logic [N_CH-1:0] out_d;

  // A channel only follows sync after FILT_CYC consecutive disagreeing samples;
  // any agreeing sample in between discards the partial count.
  always_comb begin
    out_d = out_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (sync_lvl[i] != out_q[i]) begin
        if (cnt_q[i] == CW'(FILT_CYC - 1)) out_d[i] = sync_lvl[i];
        else                               cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_b or negedge rst_b_n) begin
    if (!rst_b_n) begin
      out_q <= RST_VAL;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= '0;
    end else begin
      out_q <= out_d;
      for (int i = 0; i < N_CH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_b = out_q;
`else
  assign out_b = sync_lvl;
`endif

  // Resetting prev_q to RST_VAL keeps both pulses quiet on the first cycle after release.
  always_ff @(posedge clk_b or negedge rst_b_n) begin
    if (!rst_b_n) prev_q <= RST_VAL;
    else          prev_q <= out_b;
  end

  assign rise_b = out_b & ~prev_q;
  assign fall_b = ~out_b & prev_q;

endmodule
